beep_arbiter: RTL

//  Owns the single buzzer output. Arbitrates four event requesters (key click, timeout,

---
 rtl/game_pkg.sv | 58 +++++
 rtl/tone_gen.sv | 39 +++
 rtl/beep_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: requester indices, beep arbiter state encoding and the fixed tone pattern
// for each requester.
package game_pkg;

    localparam int REQ_N = 4;

    localparam logic [1:0] REQ_CLICK   = 2'd0;
    localparam logic [1:0] REQ_TIMEOUT = 2'd1;
    localparam logic [1:0] REQ_FAIL    = 2'd2;
    localparam logic [1:0] REQ_SUCCESS = 2'd3;

    // lowest tone in the table; sizes the half-period counter
    localparam int MIN_TONE_HZ = 500;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int tone_hz(input logic [1:0] idx);
        case (idx)
            REQ_CLICK:   return 2000;
            REQ_TIMEOUT: return 1000;
            REQ_FAIL:    return 500;
            default:     return 2000;
        endcase
    endfunction

    function automatic int on_ms(input logic [1:0] idx);
        case (idx)
            REQ_CLICK:   return 30;
            REQ_TIMEOUT: return 200;
            REQ_FAIL:    return 500;
            default:     return 100;
        endcase
    endfunction

    function automatic int off_ms(input logic [1:0] idx);
        case (idx)
            REQ_CLICK:   return 0;
            REQ_TIMEOUT: return 200;
            REQ_FAIL:    return 0;
            default:     return 100;
        endcase
    endfunction

    function automatic int beep_cnt(input logic [1:0] idx);
        case (idx)
            REQ_CLICK:   return 1;
            REQ_TIMEOUT: return 2;
            REQ_FAIL:    return 1;
            default:     return 3;
        endcase
    endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave generator. Output is registered and starts high on the first
// enabled cycle; restart forces a fresh high phase while already enabled.
module tone_gen #(
    parameter int HALF_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);
    logic [HALF_W-1:0] cnt;
    logic              en_q;

    // en describes the coming cycle, so wave is already correct on the first ON cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            wave <= 1'b0;
            en_q <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                cnt  <= '0;
                wave <= 1'b0;
            end else if (restart || !en_q) begin
                cnt  <= half - HALF_W'(1);
                wave <= 1'b1;
            end else if (cnt == '0) begin
                cnt  <= half - HALF_W'(1);
                wave <= ~wave;
            end else begin
                cnt <= cnt - HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/beep_arbiter.sv
// beep_arbiter: owns the buzzer pin, arbitrates click/timeout/fail/success requests and
// plays each requester's tone pattern. Define BEEP_QUEUE_EN to queue busy-time requests.
//
// state | meaning
// IDLE  | nothing playing, waiting for a pending request
// ON    | tone segment of the granted pattern
// OFF   | silent gap between beeps of the granted pattern
// DONE  | pattern completed, over pulses this cycle
module beep_arbiter
    import game_pkg::*;
#(
    parameter int CLK_HZ = 1_000_000,
    parameter int MS_W   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mute,
    output logic       beep,
    output logic [3:0] grant,
    output logic       busy,
    output logic       over,
    output logic       drop
);
    localparam int DIV    = CLK_HZ / 1000;
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int HALF_W = $clog2(CLK_HZ / (2 * MIN_TONE_HZ) + 1);

    localparam logic [HALF_W-1:0] HALF_CLICK   = HALF_W'(CLK_HZ / (2 * tone_hz(REQ_CLICK)));
    localparam logic [HALF_W-1:0] HALF_TIMEOUT = HALF_W'(CLK_HZ / (2 * tone_hz(REQ_TIMEOUT)));
    localparam logic [HALF_W-1:0] HALF_FAIL    = HALF_W'(CLK_HZ / (2 * tone_hz(REQ_FAIL)));
    localparam logic [HALF_W-1:0] HALF_SUCCESS = HALF_W'(CLK_HZ / (2 * tone_hz(REQ_SUCCESS)));

    state_t            state, state_nxt;
    logic [1:0]        gidx, gidx_nxt, top_idx;
    logic [1:0]        left, left_nxt;
    logic [3:0]        pending, accept, above, clr;
    logic [MS_W-1:0]   seg_ms, seg_dur;
    logic [DIV_W-1:0]  ms_div;
    logic              tick, top_valid, preempt, load, seg_done, seg_clr;
    logic              tone_en, wave;
    logic [HALF_W-1:0] half;

    assign tick = (ms_div == '0);

    always_comb begin
        top_valid = |pending;
        top_idx   = 2'd0;
        above     = 4'b0000;
        for (int i = 0; i < REQ_N; i++) begin
            if (pending[i]) top_idx = 2'(i);
            above[i] = (2'(i) > gidx);
        end
    end

    assign preempt  = top_valid && (top_idx > gidx) && (state == ST_ON || state == ST_OFF);
    assign seg_dur  = (state == ST_ON) ? MS_W'(on_ms(gidx)) : MS_W'(off_ms(gidx));
    assign seg_done = (seg_ms == seg_dur);

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        left_nxt  = left;
        load      = 1'b0;
        over      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (top_valid) begin
                    state_nxt = ST_ON;
                    load      = 1'b1;
                end
            end
            ST_ON: begin
                if (preempt) begin
                    load = 1'b1;
                end else if (seg_done) begin
                    if (left != 2'd0 && off_ms(gidx) != 0) state_nxt = ST_OFF;
                    else                                   state_nxt = ST_DONE;
                end
            end
            ST_OFF: begin
                if (preempt) begin
                    state_nxt = ST_ON;
                    load      = 1'b1;
                end else if (seg_done) begin
                    state_nxt = ST_ON;
                    left_nxt  = left - 2'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                over      = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (load) begin
            gidx_nxt = top_idx;
            left_nxt = 2'(beep_cnt(top_idx) - 1);
        end
    end

    assign seg_clr = load || (state_nxt != state);
    assign clr     = load ? (4'b0001 << top_idx) : 4'b0000;

`ifdef BEEP_QUEUE_EN
    assign accept = req;
`else
    // while busy only strictly higher priority survives; it will preempt
    assign accept = (state == ST_IDLE) ? req : (req & above);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            gidx    <= REQ_CLICK;
            left    <= 2'd0;
            pending <= 4'b0000;
            seg_ms  <= '0;
            ms_div  <= DIV_W'(DIV - 1);
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            gidx    <= gidx_nxt;
            left    <= left_nxt;
            pending <= (pending & ~clr) | accept;
            drop    <= |(req & ~accept);
            ms_div  <= tick ? DIV_W'(DIV - 1) : ms_div - DIV_W'(1);
            if (seg_clr)                   seg_ms <= '0;
            else if (tick && seg_ms != '1) seg_ms <= seg_ms + MS_W'(1);
        end
    end

    always_comb begin
        case (gidx_nxt)
            REQ_CLICK:   half = HALF_CLICK;
            REQ_TIMEOUT: half = HALF_TIMEOUT;
            REQ_FAIL:    half = HALF_FAIL;
            default:     half = HALF_SUCCESS;
        endcase
    end

    assign tone_en = (state_nxt == ST_ON);

    tone_gen #(.HALF_W(HALF_W)) u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .restart (load),
        .half    (half),
        .wave    (wave)
    );

    assign busy  = (state != ST_IDLE);
    assign grant = busy ? (4'b0001 << gidx) : 4'b0000;
    assign beep  = wave & ~mute;

endmodule
